// File: rtl/add_pkg.sv
// Shared types for the multi-cycle adder/subtractor: opcode encoding,
// controller states and the initial-carry rule applied at operand accept.
package add_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Subtraction is A + ~B + carry, so SUB forces carry 1 and SBC takes cin.
    function automatic logic init_carry(input op_e o, input logic cin);
        case (o)
            OP_ADD:  return 1'b0;
            OP_SUB:  return 1'b1;
            default: return cin;
        endcase
    endfunction

    // Low opcode bit selects the inverted B operand (SUB/SBC).
    function automatic logic is_sub(input op_e o);
        return o[0];
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple slice. c_msb is the carry into the top bit
// of the slice; on the most significant chunk it feeds the overflow flag.
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] cy;

    // Ripple the carry bit by bit through the slice.
    always_comb begin
        cy    = '0;
        s     = '0;
        cy[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]    = a[i] ^ b[i] ^ cy[i];
            cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
        end
    end

    assign co    = cy[CHUNK];
    assign c_msb = cy[CHUNK-1];

endmodule

// File: rtl/add_seq.sv
// Multi-cycle adder/subtractor: operands latched on start, summed CHUNK bits
// per clock LSB chunk first through one add_chunk slice, result and flags
// registered on entering DONE.
// Optional build macro ADD_SAT_EN: clamps the result to the signed extreme on
// overflow (cout stays unclamped, zero/neg follow the clamped value).
//
// state | meaning
// IDLE  | waiting for start; out/flags hold the last result
// RUN   | summing chunk k each cycle, k = 0..N-1
// DONE  | one cycle, done=1; start here is accepted back-to-back
module add_seq
    import add_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    state_e           state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res;
    logic             carry;

    logic [CHUNK-1:0] ch_a;
    logic [CHUNK-1:0] ch_b;
    logic [CHUNK-1:0] ch_s;
    logic             ch_co;
    logic             ch_cmsb;

    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] fin;
    logic             ovf_next;
    logic             last;
    op_e              op_sel;

    assign op_sel = op_e'(op);
    assign ch_a   = a_reg[k*CHUNK +: CHUNK];
    assign ch_b   = b_reg[k*CHUNK +: CHUNK];
    assign last   = (k == KW'(N - 1));

    add_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a     (ch_a),
        .b     (ch_b),
        .ci    (carry),
        .s     (ch_s),
        .co    (ch_co),
        .c_msb (ch_cmsb)
    );

    // Merge the current chunk into the partial result and form the final
    // (optionally clamped) value used when the last chunk completes.
    always_comb begin
        res_next                      = res;
        res_next[k*CHUNK +: CHUNK]    = ch_s;
        ovf_next                      = ch_cmsb ^ ch_co;
`ifdef ADD_SAT_EN
        // Wrapped sign bit set means the true result was positive.
        if (ovf_next) begin
            fin = res_next[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                    : {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            fin = res_next;
        end
`else
        fin = res_next;
`endif
    end

    // Controller, chunk counter, operand/result registers and output flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            k     <= '0;
            a_reg <= '0;
            b_reg <= '0;
            res   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
            neg   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg <= in1;
                        b_reg <= is_sub(op_sel) ? ~in2 : in2;
                        carry <= init_carry(op_sel, cin);
                        k     <= '0;
                        res   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    res   <= res_next;
                    carry <= ch_co;
                    if (last) begin
                        k     <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        out   <= fin;
                        cout  <= ch_co;
                        ovf   <= ovf_next;
                        zero  <= (fin == '0);
                        neg   <= fin[WIDTH-1];
                        state <= DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_seq.sv
// Self-checking bench for add_seq (WIDTH=16, CHUNK=4). Expected results come
// from an integer-arithmetic reference of add/sub/adc/sbc with carry, borrow
// and signed-range overflow rules. Honours ADD_SAT_EN when defined.
module tb_add_seq;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic         cin = 1'b0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;

    int vectors = 0;
    int errors  = 0;

    add_seq #(.WIDTH(W), .CHUNK(C)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .cin   (cin),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero),
        .neg   (neg)
    );

    always #5 clk = ~clk;

    // Reference: returns {out, cout, ovf, zero, neg}.
    function automatic logic [W+3:0] model(input logic [1:0] o, input logic c,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
        longint ua  = longint'(a);
        longint ub  = longint'(b);
        longint sa  = longint'($signed(a));
        longint sb  = longint'($signed(b));
        longint ci  = longint'(c);
        longint lim = longint'(1) << W;
        longint smax = (longint'(1) << (W - 1)) - 1;
        longint smin = -(longint'(1) << (W - 1));
        longint ut, st;
        logic [W-1:0] r;
        logic co, ov;
        case (o)
            2'b00: begin ut = ua + ub;           st = sa + sb;           co = (ut >= lim); end
            2'b01: begin ut = ua - ub;           st = sa - sb;           co = (ua >= ub); end
            2'b10: begin ut = ua + ub + ci;      st = sa + sb + ci;      co = (ut >= lim); end
            default: begin ut = ua - ub - (1 - ci); st = sa - sb - (1 - ci); co = (ua >= ub + (1 - ci)); end
        endcase
        r  = ut[W-1:0];
        ov = (st > smax) || (st < smin);
`ifdef ADD_SAT_EN
        if (ov) r = (st > 0) ? W'(smax) : W'(smin);
`endif
        return {r, co, ov, (r == '0), r[W-1]};
    endfunction

    // Issue one operation and wait for its done pulse; returns busy-cycle
    // count, cycles from accept to done and the captured outputs.
    task automatic issue_wait(input logic [1:0] o, input logic c,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              output int bcnt, output int lat, output logic [W+3:0] res);
        @(negedge clk);
        op = o; cin = c; in1 = a; in2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom); cin = 1'($urandom); in1 = W'($urandom); in2 = W'($urandom);
        bcnt = 0; lat = 0; res = '0;
        for (int i = 1; i <= 3 * N + 4; i++) begin
            if (done) begin
                lat = i;
                res = {out, cout, ovf, zero, neg};
                break;
            end
            if (busy) bcnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done, out, cout, ovf, zero, neg} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b out=%h cout=%b ovf=%b zero=%b neg=%b, want all 0",
                     busy, done, out, cout, ovf, zero, neg);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0]   t_op [7] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11, 2'b00};
        logic         t_ci [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] t_a  [7] = '{16'h000A, 16'h0002, 16'h000A, 16'h7FFF, 16'hFFFF, 16'h0005, 16'h8000};
        logic [W-1:0] t_b  [7] = '{16'h000A, 16'h000A, 16'h000A, 16'h0001, 16'h0000, 16'h0003, 16'h8000};
`ifdef ADD_SAT_EN
        logic [W+3:0] t_exp [7] = '{{16'h0014, 4'b0000}, {16'hFFF8, 4'b0001}, {16'h0000, 4'b1010},
                                   {16'h7FFF, 4'b0100}, {16'h0000, 4'b1010}, {16'h0001, 4'b1000},
                                   {16'h8000, 4'b1101}};
`else
        logic [W+3:0] t_exp [7] = '{{16'h0014, 4'b0000}, {16'hFFF8, 4'b0001}, {16'h0000, 4'b1010},
                                   {16'h8000, 4'b0101}, {16'h0000, 4'b1010}, {16'h0001, 4'b1000},
                                   {16'h0000, 4'b1110}};
`endif
        int bcnt, lat;
        logic [W+3:0] res;
        for (int i = 0; i < 7; i++) begin
            issue_wait(t_op[i], t_ci[i], t_a[i], t_b[i], bcnt, lat, res);
            vectors++;
            if (lat != N + 1 || bcnt != N) begin
                errors++;
                $display("FAIL directed_timing[%0d]: got done at %0d busy %0d cycles, want done at %0d busy %0d",
                         i, lat, bcnt, N + 1, N);
            end
            vectors++;
            if (res !== t_exp[i]) begin
                errors++;
                $display("FAIL directed_result[%0d]: got out=%h flags(c,v,z,n)=%b, want out=%h flags=%b",
                         i, res[W+3:4], res[3:0], t_exp[i][W+3:4], t_exp[i][3:0]);
            end
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0 || {out, cout, ovf, zero, neg} !== t_exp[i]) begin
                errors++;
                $display("FAIL directed_hold[%0d]: got done=%b busy=%b out=%h, want done=0 busy=0 out=%h held",
                         i, done, busy, out, t_exp[i][W+3:4]);
            end
        end
    endtask

    task automatic test_random();
        int bcnt, lat;
        logic [W+3:0] res, exp;
        logic [1:0] o;
        logic c;
        logic [W-1:0] a, b;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom);
            c = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            case ($urandom_range(0, 5))
                0: a = 16'h7FFF;
                1: b = 16'h8000;
                2: b = a;
                default: ;
            endcase
            exp = model(o, c, a, b);
            issue_wait(o, c, a, b, bcnt, lat, res);
            vectors++;
            if (lat != N + 1 || res !== exp) begin
                errors++;
                $display("FAIL random[%0d] op=%0d cin=%b a=%h b=%h: got lat=%0d out=%h flags=%b, want lat=%0d out=%h flags=%b",
                         i, o, c, a, b, lat, res[W+3:4], res[3:0], N + 1, exp[W+3:4], exp[3:0]);
            end
        end
    endtask

    task automatic test_start_in_run();
        logic [W+3:0] exp;
        int lat = 0;
        int late_busy = 0;
        exp = model(2'b00, 1'b0, 16'h1234, 16'h0F0F);
        @(negedge clk);
        op = 2'b00; cin = 1'b0; in1 = 16'h1234; in2 = 16'h0F0F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        op = 2'b01; in1 = 16'hAAAA; in2 = 16'h5555; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 3; i <= 12; i++) begin
            if (done) begin lat = i; break; end
            @(negedge clk);
        end
        vectors++;
        if (lat != N + 1 || {out, cout, ovf, zero, neg} !== exp) begin
            errors++;
            $display("FAIL start_in_run: got lat=%0d out=%h flags=%b, want lat=%0d out=%h flags=%b",
                     lat, out, {cout, ovf, zero, neg}, N + 1, exp[W+3:4], exp[3:0]);
        end
        repeat (8) begin
            @(negedge clk);
            if (busy || done) late_busy++;
        end
        vectors++;
        if (late_busy != 0) begin
            errors++;
            $display("FAIL start_not_queued: got %0d busy/done cycles after result, want 0", late_busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int bcnt, lat, seen = 0;
        logic [W+3:0] res;
        issue_wait(2'b00, 1'b0, 16'h8000, 16'h0001, bcnt, lat, res);
        @(negedge clk);
        op = 2'b00; in1 = 16'h0101; in2 = 16'h0202; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, done, out, cout, ovf, zero, neg} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b done=%b out=%h cout=%b ovf=%b zero=%b neg=%b, want all 0",
                     busy, done, out, cout, ovf, zero, neg);
        end
        reset = 1'b0;
        repeat (2 * N) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        vectors++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d busy/done cycles after abort, want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [W+3:0] q[$];
        logic [W+3:0] exp;
        int dones = 0;
        int last_done = -1;
        @(negedge clk);
        op = 2'($urandom); cin = 1'($urandom); in1 = W'($urandom); in2 = W'($urandom);
        start = 1'b1;
        q.push_back(model(op, cin, in1, in2));
        for (int cyc = 1; cyc <= 80 && dones < 6; cyc++) begin
            @(negedge clk);
            if (done) begin
                exp = (q.size() > 0) ? q.pop_front() : '0;
                vectors++;
                if ({out, cout, ovf, zero, neg} !== exp) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: got out=%h flags=%b, want out=%h flags=%b",
                             dones, out, {cout, ovf, zero, neg}, exp[W+3:4], exp[3:0]);
                end
                if (last_done >= 0) begin
                    vectors++;
                    if (cyc - last_done != N + 1) begin
                        errors++;
                        $display("FAIL b2b_interval[%0d]: got %0d cycles, want %0d",
                                 dones, cyc - last_done, N + 1);
                    end
                end
                last_done = cyc;
                dones++;
            end
            op = 2'($urandom); cin = 1'($urandom); in1 = W'($urandom); in2 = W'($urandom);
            if (done) q.push_back(model(op, cin, in1, in2));
        end
        vectors++;
        if (dones != 6) begin
            errors++;
            $display("FAIL b2b_count: got %0d done pulses, want 6", dones);
        end
        start = 1'b0;
        repeat (N + 3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_in_run();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
